// File: rtl/ccg_response_analyzer_if.sv
// Stimulus/response bus between the response analyzer and whatever drives and observes it.
// master: controller/CUT side; slave: analyzer side.
interface ccg_response_analyzer_if #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 10
);
    logic             start;
    logic [OUT_W-1:0] golden;
    logic [IN_W-1:0]  stim;
    logic [OUT_W-1:0] resp;
    logic             busy;
    logic             done;
    logic             pass;
    logic [OUT_W-1:0] signature;

    modport master (
        output start, golden, resp,
        input  stim, busy, done, pass, signature
    );

    modport slave (
        input  start, golden, resp,
        output stim, busy, done, pass, signature
    );
endinterface

// File: rtl/ccg_response_analyzer.sv
// Exhaustive stimulus sweep with MISR response compaction and golden-signature compare.
// Optional run/fail counters are enabled by defining CCG_ANALYZER_CNT_EN.
module ccg_response_analyzer #(
    parameter int               IN_W   = 3,
    parameter int               OUT_W  = 10,
    parameter int               SETTLE = 2,
    parameter logic [OUT_W-1:0] POLY   = 10'h009
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ccg_response_analyzer_if.slave bus
`ifdef CCG_ANALYZER_CNT_EN
    ,
    output logic [15:0]            runs,
    output logic [15:0]            fails
`endif
);

    localparam int SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
    localparam int SCW        = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
    localparam logic [SCW-1:0]  SETTLE_LAST = SCW'(SETTLE_EFF - 1);
    // One extra bit so the terminal-pattern compare cannot alias on wrap.
    localparam logic [IN_W:0]   PAT_LAST    = (IN_W+1)'((1 << IN_W) - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [SCW-1:0]   settle_r;
    logic [IN_W:0]    pat_r;
    logic [OUT_W-1:0] sig_r;
    logic [OUT_W-1:0] golden_r;
    logic             pass_r;
    logic             busy_r;
    logic             done_r;
    logic             busy_s;
    logic             done_s;

    function automatic logic [OUT_W-1:0] misr_step(input logic [OUT_W-1:0] cur,
                                                    input logic [OUT_W-1:0] din);
        logic [OUT_W-1:0] fb;
        fb        = cur[OUT_W-1] ? POLY : {OUT_W{1'b0}};
        misr_step = {cur[OUT_W-2:0], 1'b0} ^ fb ^ din;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) state_s = ST_APPLY;
                else           state_s = ST_IDLE;
            end
            ST_APPLY: begin
                if (settle_r == SETTLE_LAST) state_s = ST_SAMPLE;
                else                         state_s = ST_APPLY;
            end
            ST_SAMPLE: begin
                if (pat_r == PAT_LAST) state_s = ST_DONE;
                else                   state_s = ST_APPLY;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so busy/done leave a flop.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_s)
            ST_IDLE:   begin busy_s = 1'b0; done_s = 1'b0; end
            ST_APPLY:  begin busy_s = 1'b1; done_s = 1'b0; end
            ST_SAMPLE: begin busy_s = 1'b1; done_s = 1'b0; end
            ST_DONE:   begin busy_s = 1'b1; done_s = 1'b1; end
            default:   begin busy_s = 1'b0; done_s = 1'b0; end
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_s;
            done_r <= done_s;
        end
    end

    // Datapath: settle timer, pattern counter, MISR, golden capture, verdict.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            settle_r <= {SCW{1'b0}};
            pat_r    <= {(IN_W+1){1'b0}};
            sig_r    <= {OUT_W{1'b0}};
            golden_r <= {OUT_W{1'b0}};
            pass_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        settle_r <= {SCW{1'b0}};
                        pat_r    <= {(IN_W+1){1'b0}};
                        sig_r    <= {OUT_W{1'b0}};
                        golden_r <= bus.golden;
                        pass_r   <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    if (settle_r == SETTLE_LAST) settle_r <= {SCW{1'b0}};
                    else                         settle_r <= settle_r + SCW'(1);
                end
                ST_SAMPLE: begin
                    sig_r <= misr_step(sig_r, bus.resp);
                    // stim parks on the last pattern until the next start.
                    if (pat_r != PAT_LAST) pat_r <= pat_r + (IN_W+1)'(1);
                end
                ST_DONE: begin
                    pass_r <= (sig_r == golden_r);
                end
                default: begin
                    pass_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef CCG_ANALYZER_CNT_EN
    logic [15:0] runs_r;
    logic [15:0] fails_r;

    // Saturating completed-run and failed-run counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            runs_r  <= 16'h0000;
            fails_r <= 16'h0000;
        end else if (state_r == ST_DONE) begin
            if (runs_r != 16'hFFFF) runs_r <= runs_r + 16'd1;
            if ((sig_r != golden_r) && (fails_r != 16'hFFFF)) fails_r <= fails_r + 16'd1;
        end
    end

    assign runs  = runs_r;
    assign fails = fails_r;
`endif

    assign bus.stim      = pat_r[IN_W-1:0];
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.pass      = pass_r;
    assign bus.signature = sig_r;

endmodule

// File: tb/tb_ccg_response_analyzer.sv
// Randomized self-checking bench for ccg_response_analyzer; the CUT is a lookup table and
// the expected signature is the response polynomial reduced modulo x^10+x^3+1.
module tb_ccg_response_analyzer;

    localparam int IN_W   = 3;
    localparam int OUT_W  = 10;
    localparam int SETTLE = 2;
    localparam int NPAT   = 1 << IN_W;
    // Edges from the accepting edge to the edge that raises done.
    localparam int EXP_DONE = NPAT * (SETTLE + 1);

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [OUT_W-1:0] cut_tbl [NPAT];

    ccg_response_analyzer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

`ifdef CCG_ANALYZER_CNT_EN
    logic [15:0] runs;
    logic [15:0] fails;
`endif

    ccg_response_analyzer #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SETTLE), .POLY(10'h009)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef CCG_ANALYZER_CNT_EN
        ,
        .runs  (runs),
        .fails (fails)
`endif
    );

    assign bus.resp = cut_tbl[bus.stim];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Signature = sum over patterns of resp_i * x^(NPAT-1-i), reduced mod x^10+x^3+1.
    function automatic logic [OUT_W-1:0] model_sig();
        logic [31:0] acc;
        acc = 32'h0;
        for (int i = 0; i < NPAT; i++)
            acc = acc ^ ({22'h0, cut_tbl[i]} << (NPAT - 1 - i));
        for (int d = 31; d >= OUT_W; d--)
            if (acc[d]) acc = acc ^ (32'h409 << (d - OUT_W));
        return acc[OUT_W-1:0];
    endfunction

    task automatic fill_tbl(input bit rnd, input logic [OUT_W-1:0] val);
        for (int i = 0; i < NPAT; i++)
            cut_tbl[i] = rnd ? OUT_W'($urandom) : val;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one sweep; returns edge index of done and number of trace deviations.
    task automatic run_once(input logic [OUT_W-1:0] g, input int pulse_k,
                            output int done_at, output int trace_err);
        int   es;
        logic eb;
        logic ed;
        bus.golden = g;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.golden = OUT_W'($urandom);
        done_at    = -1;
        trace_err  = 0;
        for (int k = 0; k <= EXP_DONE + 1; k++) begin
            if (k > 0) tick();
            bus.start = (k == pulse_k) ? 1'b1 : 1'b0;
            es = k / (SETTLE + 1);
            if (es > NPAT - 1) es = NPAT - 1;
            eb = (k <= EXP_DONE);
            ed = (k == EXP_DONE);
            if (bus.stim !== IN_W'(es) || bus.busy !== eb || bus.done !== ed) trace_err++;
            if (k < EXP_DONE && bus.pass !== 1'b0) trace_err++;
            if (bus.done === 1'b1 && done_at < 0) done_at = k;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total += 5;
        if (bus.stim !== 3'd0) begin bad++; $display("FAIL reset_stim: got %h want 0", bus.stim); end
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        if (bus.pass !== 1'b0) begin bad++; $display("FAIL reset_pass: got %b want 0", bus.pass); end
        if (bus.signature !== 10'h000) begin bad++; $display("FAIL reset_sig: got %h want 000", bus.signature); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_zero_sweep();
        int da, te;
        fill_tbl(1'b0, 10'h000);
        run_once(10'h000, -1, da, te);
        total += 4;
        if (da !== EXP_DONE) begin bad++; $display("FAIL zero_done_at: got %0d want %0d", da, EXP_DONE); end
        if (te !== 0) begin bad++; $display("FAIL zero_trace: got %0d deviations want 0", te); end
        if (bus.signature !== 10'h000) begin bad++; $display("FAIL zero_sig: got %h want 000", bus.signature); end
        if (bus.pass !== 1'b1) begin bad++; $display("FAIL zero_pass: got %b want 1", bus.pass); end
    endtask

    task automatic test_ones_sweep();
        int da, te;
        fill_tbl(1'b0, 10'h001);
        run_once(10'h0FF, -1, da, te);
        total += 3;
        if (te !== 0) begin bad++; $display("FAIL ones_trace: got %0d deviations want 0", te); end
        if (bus.signature !== 10'h0FF) begin bad++; $display("FAIL ones_sig: got %h want 0ff", bus.signature); end
        if (bus.pass !== 1'b1) begin bad++; $display("FAIL ones_pass: got %b want 1", bus.pass); end
        run_once(10'h0FE, -1, da, te);
        total += 2;
        if (bus.signature !== 10'h0FF) begin bad++; $display("FAIL ones_rerun_sig: got %h want 0ff", bus.signature); end
        if (bus.pass !== 1'b0) begin bad++; $display("FAIL ones_rerun_pass: got %b want 0", bus.pass); end
    endtask

    task automatic test_random();
        int da, te;
        logic [OUT_W-1:0] exp_sig, g;
        for (int it = 0; it < 6; it++) begin
            fill_tbl(1'b1, 10'h000);
            exp_sig = model_sig();
            g = (it % 2 == 1) ? exp_sig : (exp_sig ^ OUT_W'($urandom_range(1, 1023)));
            run_once(g, -1, da, te);
            total += 3;
            if (da !== EXP_DONE || te !== 0) begin
                bad++; $display("FAIL rand_trace[%0d]: done_at %0d dev %0d want %0d/0", it, da, te, EXP_DONE);
            end
            if (bus.signature !== exp_sig) begin
                bad++; $display("FAIL rand_sig[%0d]: got %h want %h", it, bus.signature, exp_sig);
            end
            if (bus.pass !== (g == exp_sig)) begin
                bad++; $display("FAIL rand_pass[%0d]: got %b want %b", it, bus.pass, (g == exp_sig));
            end
        end
    endtask

    task automatic test_start_ignored();
        int da, te;
        logic [OUT_W-1:0] exp_sig;
        fill_tbl(1'b1, 10'h000);
        exp_sig = model_sig();
        // Pattern 3 spans edges 9..11 after acceptance.
        run_once(exp_sig, 3 * (SETTLE + 1) + 1, da, te);
        total += 3;
        if (da !== EXP_DONE) begin bad++; $display("FAIL ign_done_at: got %0d want %0d", da, EXP_DONE); end
        if (te !== 0) begin bad++; $display("FAIL ign_trace: got %0d deviations want 0", te); end
        if (bus.signature !== exp_sig || bus.pass !== 1'b1) begin
            bad++; $display("FAIL ign_result: got %h/%b want %h/1", bus.signature, bus.pass, exp_sig);
        end
    endtask

    task automatic test_reset_midrun();
        int da, te;
        logic [OUT_W-1:0] exp_sig;
        fill_tbl(1'b1, 10'h000);
        exp_sig = model_sig();
        bus.golden = exp_sig;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5 * (SETTLE + 1)) tick();
        total += 1;
        if (bus.stim !== 3'd5) begin bad++; $display("FAIL mid_pattern: got %h want 5", bus.stim); end
        rst_n = 1'b0;
        tick();
        total += 1;
        if ({bus.stim, bus.busy, bus.done, bus.pass, bus.signature} !== {3'd0, 3'b000, 10'h000}) begin
            bad++;
            $display("FAIL mid_reset: got stim=%h busy=%b done=%b pass=%b sig=%h want all 0",
                     bus.stim, bus.busy, bus.done, bus.pass, bus.signature);
        end
        rst_n = 1'b1;
        tick();
        run_once(exp_sig, -1, da, te);
        total += 2;
        if (da !== EXP_DONE || te !== 0) begin
            bad++; $display("FAIL mid_rerun_trace: done_at %0d dev %0d want %0d/0", da, te, EXP_DONE);
        end
        if (bus.signature !== exp_sig || bus.pass !== 1'b1) begin
            bad++; $display("FAIL mid_rerun_result: got %h/%b want %h/1", bus.signature, bus.pass, exp_sig);
        end
    endtask

    task automatic test_back_to_back();
        int d1, d2;
        logic [OUT_W-1:0] exp_sig;
        fill_tbl(1'b1, 10'h000);
        exp_sig = model_sig();
        d1 = -1;
        d2 = -1;
        bus.golden = exp_sig;
        bus.start  = 1'b1;
        tick();
        for (int k = 1; k <= 2 * EXP_DONE + 4; k++) begin
            tick();
            if (bus.done === 1'b1) begin
                if (d1 < 0) d1 = k;
                else if (d2 < 0) d2 = k;
            end
            if (k == EXP_DONE + 1) begin
                total++;
                if (bus.busy !== 1'b0 || bus.pass !== 1'b1) begin
                    bad++; $display("FAIL b2b_gap: got busy=%b pass=%b want 0/1", bus.busy, bus.pass);
                end
            end
            if (k == EXP_DONE + 2) begin
                total++;
                bus.start = 1'b0;
                if (bus.busy !== 1'b1 || bus.pass !== 1'b0 || bus.stim !== 3'd0) begin
                    bad++; $display("FAIL b2b_restart: got busy=%b pass=%b stim=%h want 1/0/0",
                                    bus.busy, bus.pass, bus.stim);
                end
            end
        end
        bus.start = 1'b0;
        total += 2;
        if (d1 !== EXP_DONE) begin bad++; $display("FAIL b2b_done1: got %0d want %0d", d1, EXP_DONE); end
        if (d2 !== 2 * EXP_DONE + 2) begin bad++; $display("FAIL b2b_done2: got %0d want %0d", d2, 2 * EXP_DONE + 2); end
    endtask

`ifdef CCG_ANALYZER_CNT_EN
    task automatic test_counters();
        int da, te;
        logic [OUT_W-1:0] exp_sig;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        fill_tbl(1'b1, 10'h000);
        exp_sig = model_sig();
        run_once(exp_sig, -1, da, te);
        run_once(exp_sig ^ 10'h001, -1, da, te);
        total += 2;
        if (runs !== 16'd2) begin bad++; $display("FAIL cnt_runs: got %0d want 2", runs); end
        if (fails !== 16'd1) begin bad++; $display("FAIL cnt_fails: got %0d want 1", fails); end
    endtask
`endif

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.golden = 10'h000;
        fill_tbl(1'b0, 10'h000);
        test_reset();
        test_zero_sweep();
        test_ones_sweep();
        test_random();
        test_start_ignored();
        test_reset_midrun();
        test_back_to_back();
`ifdef CCG_ANALYZER_CNT_EN
        test_counters();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ccg_response_analyzer.md
# ccg_response_analyzer

Sequential stimulus/response analyzer for the generated 3-input, 10-output combinational circuits in the CCGRCG dataset. It drives every input pattern into the circuit-under-test exhaustively, waits a configurable settle time, and folds each output word into a multiple-input signature register (MISR). At the end of the sweep it compares the signature against a golden value. It sits on the observing side of the generated netlists and produces pass/fail labels for dataset validation.

## Interface

Parameters:
- `IN_W`, 3, CUT input width; sweep length is 2^IN_W patterns.
- `OUT_W`, 10, CUT output width and MISR width.
- `SETTLE`, 2, cycles each pattern is held before sampling. Minimum 1; a value of 0 behaves as 1.
- `POLY`, 10'h009, MISR feedback taps (x^10+x^3+1).

Ports:
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `start` input 1: run request; sampled only in IDLE.
- `golden` input OUT_W: expected signature; captured on the edge that accepts `start`.
- `stim` output IN_W: pattern driven to CUT inputs (x0 = bit 0).
- `resp` input OUT_W: CUT outputs (f1 = bit 0).
- `busy` output 1: high from APPLY through DONE inclusive.
- `done` output 1: one-cycle pulse in DONE.
- `pass` output 1: registered compare result; valid from DONE until the next accepted `start`.
- `signature` output OUT_W: MISR contents; holds its final value after the run.

## Operation

FSM with states IDLE, APPLY, SAMPLE, DONE.
- **IDLE**
  - If `start`=1: clear the MISR to 0, set `stim`=0, capture `golden`, clear `pass`, go to APPLY.
- **APPLY**
  - Hold `stim` for SETTLE cycles using a settle counter, then go to SAMPLE.
- **SAMPLE** (one cycle)
  - MISR update: `sig <= {sig[OUT_W-2:0],1'b0} ^ (sig[OUT_W-1] ? POLY : 0) ^ resp`.
  - If `stim` = 2^IN_W-1: go to DONE.
  - Otherwise: `stim <= stim+1` and return to APPLY.
- **DONE** (one cycle)
  - `done`=1, `pass <= (sig == golden_q)`, go to IDLE.
- Arithmetic and width rules:
  - The pattern counter is IN_W+1 bits internally so the terminal-pattern test never aliases on wrap.
  - `stim` never wraps visibly; it stays at the last pattern through DONE and returns to 0 only on the next accepted start.
- Boundary conditions:
  - `start` while `busy`: ignored, no restart.
  - `start` held high continuously: a new run begins the cycle after DONE.
  - `golden` changing mid-run: no effect.
  - `rst_n`=0 at any point (including mid-run): next edge gives IDLE, `stim`=0, `signature`=0, `pass`=0, `busy`=0, `done`=0.

## Timing

- Reset value of every output is 0.
- Start accepted at edge E.
  - Each pattern occupies SETTLE+1 cycles.
  - `done` is high in cycle E + 2^IN_W·(SETTLE+1) + 1. With defaults that is cycle E+25.
- `resp` is sampled only in SAMPLE. The CUT must settle within SETTLE cycles of a `stim` change.
- `pass` updates on the same edge on which `done` falls.

## Configuration

- `CCG_ANALYZER_CNT_EN` defined: adds two ports.
  - `runs` output 16: completed runs.
  - `fails` output 16: runs with `pass`=0.
  - Both increment on the DONE cycle, saturate at 16'hFFFF, and reset to 0.
- Not defined: the ports and counters are absent. All other behaviour is identical.

## Test plan

- Reset: hold `rst_n`=0 for 2 cycles -> `stim`=0, `busy`=0, `done`=0, `pass`=0, `signature`=10'h000.
- Sweep with `resp`=0 and `golden`=10'h000, start at edge E:
  - `stim` steps 0..7, each value held 3 cycles.
  - `done` pulses at E+25, `signature`=10'h000, `pass`=1.
- Sweep with `resp`=10'h001:
  - `golden`=10'h0FF -> `signature`=10'h0FF, `pass`=1.
  - Rerun with `golden`=10'h0FE -> `pass`=0.
- Pulse `start` again during pattern 3 -> ignored; `done` still pulses at E+25.
- Assert `rst_n`=0 during pattern 5, then restart -> all outputs return to 0 first; the full sweep repeats with the same signature.
- With `CCG_ANALYZER_CNT_EN`: run one pass and one fail -> `runs`=2, `fails`=1. Preload `runs`=16'hFFFF and run once -> `runs` stays at 16'hFFFF.
